// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   - op_e    : operation encodings carried on the op port
//   - state_e : sequencer states
//   - MULDIV_XLEN / MULDIV_CNT_W / MULDIV_ITERS : default width, counter width, iteration count
package muldiv_pkg;

    localparam int unsigned MULDIV_XLEN  = 32;
    localparam int unsigned MULDIV_CNT_W = 6;
    // One datapath bit per ITER cycle.
    localparam int unsigned MULDIV_ITERS = MULDIV_XLEN;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PREP = 2'b01,
        ITER = 2'b10,
        FIX  = 2'b11
    } state_e;

    function automatic logic op_is_mul(input op_e op);
        return (op == OP_MULTU) || (op == OP_MULT);
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between decode/execute and the multiply/divide sequencer.
//   master : start, op, rs, rt, hi_we, lo_we, wdata  ->  busy, done, hi, lo, div_by_zero
//   slave  : the sequencer side (muldiv_seq)
interface muldiv_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs;
    logic [XLEN-1:0] rt;
    logic            hi_we;
    logic            lo_we;
    logic [XLEN-1:0] wdata;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            div_by_zero;

    modport master (
        output start, op, rs, rt, hi_we, lo_we, wdata,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, rs, rt, hi_we, lo_we, wdata,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_addsub33.sv
// Shared add/subtract used by both the multiply accumulate and the divide trial subtract.
//   a, b : operands (W bits, W = XLEN + 1)
//   sub  : 1 -> a - b, 0 -> a + b
//   sum  : result, sign : result MSB
module muldiv_addsub33 #(
    parameter int unsigned W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         sign
);
    logic [W-1:0] b_eff;

    always_comb begin
        b_eff = sub ? ~b : b;
        sum   = a + b_eff + {{(W-1){1'b0}}, sub};
        sign  = sum[W-1];
    end
endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MIPS multiply/divide sequencer owning HI/LO.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, over a shared
// (XLEN+1)-bit add/subtract. Sequence: IDLE -> PREP -> ITER (XLEN cycles) -> FIX -> IDLE.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : muldiv_seq_if.slave (start/op/rs/rt, MTHI/MTLO writes, busy/done/hi/lo/div_by_zero)
// Optional build macro MULDIV_EARLY_OUT_EN: multiply leaves ITER as soon as the remaining
// multiplier bits are zero (at least one iteration); FIX applies the residual shift.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = MULDIV_XLEN,
    parameter int unsigned CNT_W = MULDIV_CNT_W
) (
    input logic         clk,
    input logic         rst_n,
    muldiv_seq_if.slave bus
);
    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [XLEN-1:0] rs_q, rs_d;     // operands as issued, kept for the divide-by-zero result
    logic [XLEN-1:0] rt_q, rt_d;
    logic [XLEN-1:0] dvs_q, dvs_d;   // |multiplicand| or |divisor|
    logic [XLEN-1:0] acc_q, acc_d;   // product high half / partial remainder
    logic [XLEN-1:0] wrk_q, wrk_d;   // multiplier-then-product-low / dividend-then-quotient
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            neg_quo_q, neg_quo_d;   // result (product or quotient) sign
    logic            neg_rem_q, neg_rem_d;   // remainder takes the dividend's sign
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;

    logic            is_mul;
    logic            is_signed;
    logic [XLEN:0]   as_a;
    logic [XLEN:0]   as_sum;
    logic            as_sign;
    logic [XLEN:0]   mul_sum;
    logic            rs_neg;
    logic            rt_neg;
    logic [XLEN-1:0] rs_abs;
    logic [XLEN-1:0] rt_abs;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
`ifdef MULDIV_EARLY_OUT_EN
    logic [XLEN-1:0] rest_mask;
    logic            rest_zero;
`endif

    assign is_mul    = op_is_mul(op_q);
    assign is_signed = op_is_signed(op_q);

    // Multiply adds the multiplicand to the accumulator; divide subtracts the divisor from
    // the remainder shifted left with the next dividend bit.
    assign as_a = is_mul ? {1'b0, acc_q} : {acc_q, wrk_q[XLEN-1]};

    muldiv_addsub33 #(
        .W (XLEN + 1)
    ) u_addsub (
        .a    (as_a),
        .b    ({1'b0, dvs_q}),
        .sub  (~is_mul),
        .sum  (as_sum),
        .sign (as_sign)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        dvs_d     = dvs_q;
        acc_d     = acc_q;
        wrk_d     = wrk_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;

        rs_neg  = is_signed & rs_q[XLEN-1];
        rt_neg  = is_signed & rt_q[XLEN-1];
        rs_abs  = rs_neg ? -rs_q : rs_q;
        rt_abs  = rt_neg ? -rt_q : rt_q;
        mul_sum = wrk_q[0] ? as_sum : {1'b0, acc_q};
        prod    = {acc_q, wrk_q};
        quo_fix = neg_quo_q ? -wrk_q : wrk_q;
        rem_fix = neg_rem_q ? -acc_q : acc_q;
`ifdef MULDIV_EARLY_OUT_EN
        // Multiplier bits not yet consumed after this iteration: wrk_q[cnt_q-1:1].
        rest_mask = (XLEN'(1) << (cnt_q - CNT_W'(1))) - XLEN'(1);
        rest_zero = ((wrk_q >> 1) & rest_mask) == '0;
        // Product sits left-aligned by the iterations that were skipped.
        prod = prod >> cnt_q;
`endif
        if (neg_quo_q) begin
            prod = -prod;
        end

        case (state_q)
            IDLE: begin
                if (bus.hi_we) begin
                    hi_d = bus.wdata;
                end
                if (bus.lo_we) begin
                    lo_d = bus.wdata;
                end
                if (bus.start) begin
                    op_d    = op_e'(bus.op);
                    rs_d    = bus.rs;
                    rt_d    = bus.rt;
                    dbz_d   = 1'b0;
                    state_d = PREP;
                end
            end

            PREP: begin
                dvs_d     = is_mul ? rs_abs : rt_abs;
                wrk_d     = is_mul ? rt_abs : rs_abs;
                acc_d     = '0;
                neg_quo_d = rs_neg ^ rt_neg;
                neg_rem_d = rs_neg;
                cnt_d     = CNT_W'(XLEN);
                state_d   = ITER;
            end

            ITER: begin
                if (is_mul) begin
                    acc_d = mul_sum[XLEN:1];
                    wrk_d = {mul_sum[0], wrk_q[XLEN-1:1]};
                end else if (!as_sign) begin
                    acc_d = as_sum[XLEN-1:0];
                    wrk_d = {wrk_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[XLEN-2:0], wrk_q[XLEN-1]};
                    wrk_d = {wrk_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
`ifdef MULDIV_EARLY_OUT_EN
                if (is_mul && rest_zero) begin
                    state_d = FIX;
                end
`endif
            end

            FIX: begin
                if (is_mul) begin
                    hi_d = prod[2*XLEN-1:XLEN];
                    lo_d = prod[XLEN-1:0];
                end else if (rt_q == '0) begin
                    hi_d  = rs_q;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= OP_MULTU;
            rs_q      <= '0;
            rt_q      <= '0;
            dvs_q     <= '0;
            acc_q     <= '0;
            wrk_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            dvs_q     <= dvs_d;
            acc_q     <= acc_d;
            wrk_q     <= wrk_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: the driver pushes the expected HI/LO/flag and commit
// cycle for every accepted operation; a monitor pops and compares on each done pulse.
module tb_muldiv_seq;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    muldiv_seq_if #(.XLEN(32)) bus ();

    muldiv_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference: plain MIPS arithmetic semantics.
    function automatic void ref_model(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] h,
                                      output logic [31:0] l, output logic z);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        z  = 1'b0;
        h  = '0;
        l  = '0;
        if (op == 2'b00) begin
            p = {32'b0, a} * {32'b0, b};
            h = p[63:32];
            l = p[31:0];
        end else if (op == 2'b01) begin
            p = 64'(sa * sb);
            h = p[63:32];
            l = p[31:0];
        end else if (b == 32'h0) begin
            h = a;
            l = 32'hFFFF_FFFF;
            z = 1'b1;
        end else if (op == 2'b10) begin
            l = a / b;
            h = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            l = 32'h8000_0000;
            h = 32'h0;
        end else begin
            q = sa / sb;
            r = sa % sb;
            l = q[31:0];
            h = r[31:0];
        end
    endfunction

    // Iterations spent in ITER: XLEN, or the multiplier's bit length (min 1) with early-out.
    function automatic int exp_iters(input logic [1:0] op, input logic [31:0] b);
        logic [31:0] m;
        int n;
        m = (op == 2'b01 && b[31]) ? -b : b;
        n = 0;
        while (m != 0) begin
            n++;
            m = m >> 1;
        end
        if (n < 1) n = 1;
        return (EARLY && !op[1]) ? n : 32;
    endfunction

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (bus.busy !== 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (bus.busy !== 1'b0) fail_now("wait_idle");
    endtask

    // Issue after edge E so the DUT samples start at E+1; commit lands at E+3+iters.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit mt, input string tag);
        exp_t e;
        logic [31:0] w;
        wait_idle();
        @(posedge clk);
        #1;
        w = $urandom;
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs    = a;
        bus.rt    = b;
        bus.hi_we = mt;
        bus.lo_we = mt;
        bus.wdata = w;
        ref_model(op, a, b, e.hi, e.lo, e.dbz);
        e.cyc = cyc + 3 + exp_iters(op, b);
        e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.rs    = $urandom;
        bus.rt    = $urandom;
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        check({tag, "_dbz_clr"}, 64'(bus.div_by_zero), 64'd0);
        if (mt) check({tag, "_mt_same_edge"}, {bus.hi, bus.lo}, {w, w});
    endtask

    task automatic do_mt(input logic [31:0] vh, input logic [31:0] vl);
        wait_idle();
        @(posedge clk);
        #1;
        bus.hi_we = 1'b1;
        bus.wdata = vh;
        @(posedge clk);
        #1;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b1;
        bus.wdata = vl;
        @(posedge clk);
        #1;
        bus.lo_we = 1'b0;
        check("mthi", 64'(bus.hi), 64'(vh));
        check("mtlo", 64'(bus.lo), 64'(vl));
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                e = exp_q.pop_front();
                check({e.tag, "_hi"}, 64'(bus.hi), 64'(e.hi));
                check({e.tag, "_lo"}, 64'(bus.lo), 64'(e.lo));
                check({e.tag, "_dbz"}, 64'(bus.div_by_zero), 64'(e.dbz));
                check({e.tag, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int k;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.rs    = '0;
        bus.rt    = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;

        #1;
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        do_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, "mult_neg");
        do_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, "div_neg");
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        do_op(2'b10, 32'h0000_0064, 32'h0000_0000, 1'b0, "divu_zero");
        do_op(2'b00, 32'h0000_0005, 32'h0000_0003, 1'b0, "multu_5x3");
        do_op(2'b11, 32'h0000_1234, 32'hFFFF_FFF0, 1'b1, "div_with_mt");
        do_op(2'b01, 32'h8000_0000, 32'h0000_0000, 1'b0, "mult_zero");

        // start + MTHI while busy are ignored; HI/LO hold until commit.
        do_mt(32'hAAAA_5555, 32'h1234_5678);
        do_op(2'b00, 32'h0000_0002, 32'h0000_0003, 1'b0, "multu_2x3");
        repeat (8) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.rs    = 32'h0000_0007;
        bus.rt    = 32'h0000_0009;
        bus.hi_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        check("busy_hold_hi", 64'(bus.hi), 64'h0000_0000_AAAA_5555);
        check("busy_hold_lo", 64'(bus.lo), 64'h0000_0000_1234_5678);

        // Abort mid-operation with reset: no commit, no done.
        do_op(2'b00, 32'h0001_2345, 32'h0006_789A, 1'b0, "multu_abort");
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("abort_hi", 64'(bus.hi), 64'd0);
        check("abort_lo", 64'(bus.lo), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: ra = 32'hFFFF_FFFF;
                2: ra = $urandom_range(0, 20);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: rb = 32'h0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 40);
                3: rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            do_op(rop, ra, rb, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) fail_now("drain");
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
